vga_sync_gen: RTL and testbench



---
 rtl/vga_sync_gen.sv | 122 ++++++++++++
 tb/tb_vga_sync_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator with active-low Hsync/Vsync, DE and aligned pixel coordinates.
// Optional feature macro VGASYNC_PIXADDR_EN adds the linear active-pixel address output pixaddr.
module vga_sync_gen #(
   parameter int HSIZE = 640,
   parameter int HFP   = 16,
   parameter int HSW   = 96,
   parameter int HBP   = 48,
   parameter int VSIZE = 480,
   parameter int VFP   = 10,
   parameter int VSW   = 2,
   parameter int VBP   = 33
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        CE,
   output logic        Hsync,
   output logic        Vsync,
   output logic        DE,
   output logic [13:0] hpos,
   output logic [11:0] vpos,
   output logic        frame_start
`ifdef VGASYNC_PIXADDR_EN
   ,
   output logic [23:0] pixaddr
`endif
);

   localparam int HTOTAL = HSIZE + HFP + HSW + HBP;
   localparam int VTOTAL = VSIZE + VFP + VSW + VBP;

   localparam logic [13:0] H_ACT  = 14'(HSIZE);
   localparam logic [13:0] HS_BEG = 14'(HSIZE + HFP);
   localparam logic [13:0] HS_END = 14'(HSIZE + HFP + HSW);
   localparam logic [13:0] H_LAST = 14'(HTOTAL - 1);
   localparam logic [11:0] V_ACT  = 12'(VSIZE);
   localparam logic [11:0] VS_BEG = 12'(VSIZE + VFP);
   localparam logic [11:0] VS_END = 12'(VSIZE + VFP + VSW);
   localparam logic [11:0] V_LAST = 12'(VTOTAL - 1);

   logic [13:0] r_h;
   logic [11:0] r_v;
   logic        r_hsync;
   logic        r_vsync;
   logic        r_de;
   logic [13:0] r_hpos;
   logic [11:0] r_vpos;
   logic        r_frame_start;

   logic        w_h_active;
   logic        w_v_active;
   logic        w_h_sync;
   logic        w_v_sync;
   logic        w_first;
   logic        w_h_last;
   logic        w_v_last;
   logic [13:0] w_h_next;
   logic [11:0] w_v_next;

   assign w_h_active = (r_h < H_ACT);
   assign w_v_active = (r_v < V_ACT);
   assign w_h_sync   = (r_h >= HS_BEG) && (r_h < HS_END);
   assign w_v_sync   = (r_v >= VS_BEG) && (r_v < VS_END);
   assign w_first    = (r_h == 14'd0) && (r_v == 12'd0);

   // Wrap on >= so a corrupted counter can never run past the raster.
   assign w_h_last = (r_h >= H_LAST);
   assign w_v_last = (r_v >= V_LAST);
   assign w_h_next = w_h_last ? 14'd0 : r_h + 14'd1;
   assign w_v_next = w_h_last ? (w_v_last ? 12'd0 : r_v + 12'd1) : r_v;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_h           <= 14'd0;
         r_v           <= 12'd0;
         r_hsync       <= 1'b1;
         r_vsync       <= 1'b1;
         r_de          <= 1'b0;
         r_hpos        <= 14'd0;
         r_vpos        <= 12'd0;
         r_frame_start <= 1'b0;
      end else begin
         r_frame_start <= 1'b0;
         if (CE) begin
            r_hpos        <= r_h;
            r_vpos        <= r_v;
            r_de          <= w_h_active && w_v_active;
            r_hsync       <= ~w_h_sync;
            r_vsync       <= ~w_v_sync;
            r_frame_start <= w_first;
            r_h           <= w_h_next;
            r_v           <= w_v_next;
         end
      end
   end

   assign Hsync       = r_hsync;
   assign Vsync       = r_vsync;
   assign DE          = r_de;
   assign hpos        = r_hpos;
   assign vpos        = r_vpos;
   assign frame_start = r_frame_start;

`ifdef VGASYNC_PIXADDR_EN
   logic [23:0] r_pixaddr;

   // Advance when the pixel being presented is active, so the last address holds through blanking.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_pixaddr <= 24'd0;
      end else if (CE) begin
         if (w_first) begin
            r_pixaddr <= 24'd0;
         end else if (w_h_active && w_v_active) begin
            r_pixaddr <= r_pixaddr + 24'd1;
         end
      end
   end

   assign pixaddr = r_pixaddr;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed self-checking bench for vga_sync_gen using a reduced raster (25x19 total) to keep runs short.
module tb_vga_sync_gen;

   localparam int HSIZE  = 16;
   localparam int HFP    = 2;
   localparam int HSW    = 4;
   localparam int HBP    = 3;
   localparam int VSIZE  = 12;
   localparam int VFP    = 2;
   localparam int VSW    = 2;
   localparam int VBP    = 3;
   localparam int HTOTAL = HSIZE + HFP + HSW + HBP;
   localparam int VTOTAL = VSIZE + VFP + VSW + VBP;
   localparam int FRAME  = HTOTAL * VTOTAL;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        CE;
   logic        Hsync;
   logic        Vsync;
   logic        DE;
   logic [13:0] hpos;
   logic [11:0] vpos;
   logic        frame_start;
`ifdef VGASYNC_PIXADDR_EN
   logic [23:0] pixaddr;
`endif

   int vectors     = 0;
   int miscompares = 0;

   vga_sync_gen #(
      .HSIZE(HSIZE), .HFP(HFP), .HSW(HSW), .HBP(HBP),
      .VSIZE(VSIZE), .VFP(VFP), .VSW(VSW), .VBP(VBP)
   ) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .CE         (CE),
      .Hsync      (Hsync),
      .Vsync      (Vsync),
      .DE         (DE),
      .hpos       (hpos),
      .vpos       (vpos),
      .frame_start(frame_start)
`ifdef VGASYNC_PIXADDR_EN
      ,
      .pixaddr    (pixaddr)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      CE    = 1'b1;
      repeat (3) tick();
      RESET = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      CE    = 1'b1;
      repeat (3) tick();
      vectors += 6;
      if (Hsync !== 1'b1) begin miscompares++; $display("FAIL reset_hsync got=%b exp=1", Hsync); end
      if (Vsync !== 1'b1) begin miscompares++; $display("FAIL reset_vsync got=%b exp=1", Vsync); end
      if (DE !== 1'b0) begin miscompares++; $display("FAIL reset_de got=%b exp=0", DE); end
      if (hpos !== 14'd0) begin miscompares++; $display("FAIL reset_hpos got=%0d exp=0", hpos); end
      if (vpos !== 12'd0) begin miscompares++; $display("FAIL reset_vpos got=%0d exp=0", vpos); end
      if (frame_start !== 1'b0) begin miscompares++; $display("FAIL reset_fs got=%b exp=0", frame_start); end
`ifdef VGASYNC_PIXADDR_EN
      vectors++;
      if (pixaddr !== 24'd0) begin miscompares++; $display("FAIL reset_pixaddr got=%0d exp=0", pixaddr); end
`endif
      RESET = 1'b0;
      $display("test_reset done");
   endtask

   task automatic test_line();
      int eh, ev, de_cnt, hs_cnt;
      logic e_de, e_hs;
      de_cnt = 0;
      hs_cnt = 0;
      do_reset();
      for (int i = 0; i < HTOTAL + 2; i++) begin
         tick();
         eh   = i % HTOTAL;
         ev   = i / HTOTAL;
         e_de = (eh < HSIZE);
         e_hs = !((eh >= HSIZE + HFP) && (eh < HSIZE + HFP + HSW));
         if (i < HTOTAL) begin
            de_cnt += (DE === 1'b1) ? 1 : 0;
            hs_cnt += (Hsync === 1'b0) ? 1 : 0;
         end
         vectors += 5;
         if (hpos !== 14'(eh)) begin miscompares++; $display("FAIL line_hpos cyc=%0d got=%0d exp=%0d", i, hpos, eh); end
         if (vpos !== 12'(ev)) begin miscompares++; $display("FAIL line_vpos cyc=%0d got=%0d exp=%0d", i, vpos, ev); end
         if (DE !== e_de) begin miscompares++; $display("FAIL line_de cyc=%0d got=%b exp=%b", i, DE, e_de); end
         if (Hsync !== e_hs) begin miscompares++; $display("FAIL line_hsync cyc=%0d got=%b exp=%b", i, Hsync, e_hs); end
         if (frame_start !== (i == 0)) begin miscompares++; $display("FAIL line_fs cyc=%0d got=%b exp=%b", i, frame_start, (i == 0)); end
      end
      vectors += 2;
      if (de_cnt != HSIZE) begin miscompares++; $display("FAIL line_de_count got=%0d exp=%0d", de_cnt, HSIZE); end
      if (hs_cnt != HSW) begin miscompares++; $display("FAIL line_hsync_count got=%0d exp=%0d", hs_cnt, HSW); end
      $display("test_line done: de_count=%0d hsync_low=%0d", de_cnt, hs_cnt);
   endtask

   task automatic test_frame();
      int eh, ev, de_cnt, vs_cnt, fs_cnt, fs_last;
      logic e_de, e_vs, e_fs;
      eh = 0; ev = 0; de_cnt = 0; vs_cnt = 0; fs_cnt = 0; fs_last = -1;
      do_reset();
      for (int i = 0; i <= FRAME; i++) begin
         tick();
         e_de = (eh < HSIZE) && (ev < VSIZE);
         e_vs = !((ev >= VSIZE + VFP) && (ev < VSIZE + VFP + VSW));
         e_fs = (eh == 0) && (ev == 0);
         if (i < FRAME) begin
            de_cnt += (DE === 1'b1) ? 1 : 0;
            vs_cnt += (Vsync === 1'b0) ? 1 : 0;
         end
         if (frame_start === 1'b1) begin
            fs_cnt++;
            fs_last = i;
         end
         vectors += 5;
         if (hpos !== 14'(eh)) begin miscompares++; $display("FAIL frame_hpos cyc=%0d got=%0d exp=%0d", i, hpos, eh); end
         if (vpos !== 12'(ev)) begin miscompares++; $display("FAIL frame_vpos cyc=%0d got=%0d exp=%0d", i, vpos, ev); end
         if (DE !== e_de) begin miscompares++; $display("FAIL frame_de cyc=%0d got=%b exp=%b", i, DE, e_de); end
         if (Vsync !== e_vs) begin miscompares++; $display("FAIL frame_vsync cyc=%0d got=%b exp=%b", i, Vsync, e_vs); end
         if (frame_start !== e_fs) begin miscompares++; $display("FAIL frame_fs cyc=%0d got=%b exp=%b", i, frame_start, e_fs); end
`ifdef VGASYNC_PIXADDR_EN
         if (e_de) begin
            vectors++;
            if (pixaddr !== 24'(ev * HSIZE + eh)) begin
               miscompares++;
               $display("FAIL frame_pixaddr cyc=%0d got=%0d exp=%0d", i, pixaddr, ev * HSIZE + eh);
            end
         end else if (ev >= VSIZE) begin
            vectors++;
            if (pixaddr !== 24'(HSIZE * VSIZE - 1)) begin
               miscompares++;
               $display("FAIL frame_pixaddr_hold cyc=%0d got=%0d exp=%0d", i, pixaddr, HSIZE * VSIZE - 1);
            end
         end
`endif
         if (eh == HTOTAL - 1) begin
            eh = 0;
            ev = (ev == VTOTAL - 1) ? 0 : ev + 1;
         end else begin
            eh++;
         end
      end
      vectors += 4;
      if (de_cnt != HSIZE * VSIZE) begin miscompares++; $display("FAIL frame_de_count got=%0d exp=%0d", de_cnt, HSIZE * VSIZE); end
      if (vs_cnt != VSW * HTOTAL) begin miscompares++; $display("FAIL frame_vsync_count got=%0d exp=%0d", vs_cnt, VSW * HTOTAL); end
      if (fs_cnt != 2) begin miscompares++; $display("FAIL frame_fs_count got=%0d exp=2", fs_cnt); end
      if (fs_last != FRAME) begin miscompares++; $display("FAIL frame_fs_period got=%0d exp=%0d", fs_last, FRAME); end
      $display("test_frame done: de_count=%0d vsync_low=%0d fs_period=%0d", de_cnt, vs_cnt, fs_last);
   endtask

   task automatic test_ce_stall();
      do_reset();
      CE = 1'b0;
      repeat (3) tick();
      vectors += 3;
      if (hpos !== 14'd0) begin miscompares++; $display("FAIL stall_idle_hpos got=%0d exp=0", hpos); end
      if (DE !== 1'b0) begin miscompares++; $display("FAIL stall_idle_de got=%b exp=0", DE); end
      if (frame_start !== 1'b0) begin miscompares++; $display("FAIL stall_idle_fs got=%b exp=0", frame_start); end
      CE = 1'b1;
      tick();
      vectors += 3;
      if (hpos !== 14'd0) begin miscompares++; $display("FAIL stall_first_hpos got=%0d exp=0", hpos); end
      if (DE !== 1'b1) begin miscompares++; $display("FAIL stall_first_de got=%b exp=1", DE); end
      if (frame_start !== 1'b1) begin miscompares++; $display("FAIL stall_first_fs got=%b exp=1", frame_start); end
      CE = 1'b0;
      tick();
      vectors += 3;
      if (hpos !== 14'd0) begin miscompares++; $display("FAIL stall_fs_hpos got=%0d exp=0", hpos); end
      if (DE !== 1'b1) begin miscompares++; $display("FAIL stall_fs_de got=%b exp=1", DE); end
      if (frame_start !== 1'b0) begin miscompares++; $display("FAIL stall_fs_forced got=%b exp=0", frame_start); end
      CE = 1'b1;
      repeat (10) tick();
      vectors++;
      if (hpos !== 14'd10) begin miscompares++; $display("FAIL stall_pre_hpos got=%0d exp=10", hpos); end
      CE = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors += 6;
         if (hpos !== 14'd10) begin miscompares++; $display("FAIL stall_hpos cyc=%0d got=%0d exp=10", i, hpos); end
         if (vpos !== 12'd0) begin miscompares++; $display("FAIL stall_vpos cyc=%0d got=%0d exp=0", i, vpos); end
         if (DE !== 1'b1) begin miscompares++; $display("FAIL stall_de cyc=%0d got=%b exp=1", i, DE); end
         if (Hsync !== 1'b1) begin miscompares++; $display("FAIL stall_hsync cyc=%0d got=%b exp=1", i, Hsync); end
         if (Vsync !== 1'b1) begin miscompares++; $display("FAIL stall_vsync cyc=%0d got=%b exp=1", i, Vsync); end
         if (frame_start !== 1'b0) begin miscompares++; $display("FAIL stall_fs cyc=%0d got=%b exp=0", i, frame_start); end
      end
      CE = 1'b1;
      tick();
      vectors++;
      if (hpos !== 14'd11) begin miscompares++; $display("FAIL stall_resume_hpos got=%0d exp=11", hpos); end
      repeat (8) tick();
      CE = 1'b0;
      repeat (2) tick();
      vectors += 3;
      if (hpos !== 14'd19) begin miscompares++; $display("FAIL stall_sync_hpos got=%0d exp=19", hpos); end
      if (Hsync !== 1'b0) begin miscompares++; $display("FAIL stall_sync_hsync got=%b exp=0", Hsync); end
      if (DE !== 1'b0) begin miscompares++; $display("FAIL stall_sync_de got=%b exp=0", DE); end
      CE = 1'b1;
      $display("test_ce_stall done: hpos=%0d", hpos);
   endtask

   task automatic test_mid_reset();
      do_reset();
      repeat (8 * HTOTAL + 10 + 1) tick();
      vectors += 2;
      if (hpos !== 14'd10) begin miscompares++; $display("FAIL midrst_pre_hpos got=%0d exp=10", hpos); end
      if (vpos !== 12'd8) begin miscompares++; $display("FAIL midrst_pre_vpos got=%0d exp=8", vpos); end
      RESET = 1'b1;
      tick();
      vectors += 4;
      if (hpos !== 14'd0) begin miscompares++; $display("FAIL midrst_hpos got=%0d exp=0", hpos); end
      if (vpos !== 12'd0) begin miscompares++; $display("FAIL midrst_vpos got=%0d exp=0", vpos); end
      if (DE !== 1'b0) begin miscompares++; $display("FAIL midrst_de got=%b exp=0", DE); end
      if (frame_start !== 1'b0) begin miscompares++; $display("FAIL midrst_fs got=%b exp=0", frame_start); end
      RESET = 1'b0;
      tick();
      vectors += 4;
      if (hpos !== 14'd0) begin miscompares++; $display("FAIL midrst_restart_hpos got=%0d exp=0", hpos); end
      if (vpos !== 12'd0) begin miscompares++; $display("FAIL midrst_restart_vpos got=%0d exp=0", vpos); end
      if (DE !== 1'b1) begin miscompares++; $display("FAIL midrst_restart_de got=%b exp=1", DE); end
      if (frame_start !== 1'b1) begin miscompares++; $display("FAIL midrst_restart_fs got=%b exp=1", frame_start); end
`ifdef VGASYNC_PIXADDR_EN
      vectors++;
      if (pixaddr !== 24'd0) begin miscompares++; $display("FAIL midrst_pixaddr got=%0d exp=0", pixaddr); end
`endif
      tick();
      vectors += 2;
      if (hpos !== 14'd1) begin miscompares++; $display("FAIL midrst_next_hpos got=%0d exp=1", hpos); end
      if (frame_start !== 1'b0) begin miscompares++; $display("FAIL midrst_next_fs got=%b exp=0", frame_start); end
      $display("test_mid_reset done: hpos=%0d vpos=%0d", hpos, vpos);
   endtask

   initial begin
      RESET = 1'b1;
      CE    = 1'b0;
      test_reset();
      test_line();
      test_frame();
      test_ce_stall();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
